// File: rtl/stopwatch_lap_counter_pkg.sv
// Shared constants and helpers for the stopwatch lap counter: BCD digit
// geometry, digit limits and the default parameter values of the top.
package stopwatch_lap_counter_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] TEN_SEC_MAX = 4'd5;

  localparam int DEF_MIN_DIGITS = 1;
  localparam int DEF_TICK_DIV = 1;
  localparam int DEF_SATURATE = 0;

  // Preset digits above the digit's range are forced to its maximum.
  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] value,
    input logic [DIGIT_W-1:0] max_val
  );
    if (value > max_val) begin
      clamp_digit = max_val;
    end else begin
      clamp_digit = value;
    end
  endfunction

endpackage

// File: rtl/stopwatch_lap_counter_bcd_digit.sv
// One up/down BCD digit with a parameterised maximum, synchronous preset
// and carry/borrow chaining to the next more significant digit.
module bcd_digit
  import stopwatch_lap_counter_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX_VAL = DIGIT_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               up_i,
  input  logic               cin_i,
  output logic [DIGIT_W-1:0] q_o,
  output logic [DIGIT_W-1:0] d_o,
  output logic               term_o,
  output logic               cout_o
);

  logic [DIGIT_W-1:0] val_q;
  logic [DIGIT_W-1:0] val_d;

  // term_o: digit sits at its rollover value for the current direction.
  assign term_o = up_i ? (val_q == MAX_VAL) : (val_q == 4'd0);
  assign cout_o = cin_i && term_o;

  // Next digit value: preset beats stepping; stepping wraps within 0..MAX_VAL.
  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = clamp_digit(load_val_i, MAX_VAL);
    end else if (cin_i) begin
      if (up_i) begin
        if (val_q == MAX_VAL) begin
          val_d = 4'd0;
        end else begin
          val_d = val_q + 4'd1;
        end
      end else begin
        if (val_q == 4'd0) begin
          val_d = MAX_VAL;
        end else begin
          val_d = val_q - 4'd1;
        end
      end
    end else begin
      val_d = val_q;
    end
  end

  // Digit state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q <= 4'd0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q_o = val_q;
  assign d_o = val_d;

endmodule

// File: rtl/stopwatch_lap_counter.sv
// Stopwatch with tenth-second prescaler, BCD digit chain, optional
// saturation, wrap cascade pulse and a lap/split display freeze.
module stopwatch_lap_counter
  import stopwatch_lap_counter_pkg::*;
#(
  parameter int MIN_DIGITS = DEF_MIN_DIGITS,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int SATURATE = DEF_SATURATE
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            up,
  input  logic                            load,
  input  logic [DIGIT_W*(MIN_DIGITS+3)-1:0] loadValue,
  input  logic                            lap,
  output logic [DIGIT_W*MIN_DIGITS-1:0]   minute,
  output logic [DIGIT_W-1:0]              tenSecond,
  output logic [DIGIT_W-1:0]              oneSecond,
  output logic [DIGIT_W-1:0]              tenthSecond,
  output logic                            cascade,
  output logic                            atLimit,
  output logic                            lapActive
);

  localparam int NDIG = MIN_DIGITS + 3;
  localparam int CW = DIGIT_W * NDIG;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]   presc_q;
  logic [PW-1:0]   presc_d;
  logic            tick_s;
  logic            step_s;
  logic            at_limit_s;
  logic            wrap_s;
  logic [NDIG-1:0] term_s;
  logic [CW-1:0]   cnt_q_s;
  logic [CW-1:0]   cnt_d_s;
  logic [CW-1:0]   lap_q;
  logic [CW-1:0]   lap_d;
  logic            lap_active_q;
  logic            lap_active_d;
  logic [CW-1:0]   disp_q;
  logic [CW-1:0]   disp_d;
  logic            cascade_q;

  assign tick_s = enable && (presc_q == PRESC_LAST);
  assign at_limit_s = &term_s;
  // A saturating counter simply refuses to step when already at its terminal.
  assign step_s = tick_s && !load && !((SATURATE != 0) && at_limit_s);

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam logic [DIGIT_W-1:0] MAXV = (i == 2) ? TEN_SEC_MAX : DIGIT_MAX;
    logic cin_s;
    logic cout_s;

    if (i == 0) begin : g_lsd
      assign cin_s = step_s;
    end else begin : g_chain
      assign cin_s = g_dig[i-1].cout_s;
    end

    bcd_digit #(
      .MAX_VAL(MAXV)
    ) u_digit (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load),
      .load_val_i(loadValue[i*DIGIT_W +: DIGIT_W]),
      .up_i      (up),
      .cin_i     (cin_s),
      .q_o       (cnt_q_s[i*DIGIT_W +: DIGIT_W]),
      .d_o       (cnt_d_s[i*DIGIT_W +: DIGIT_W]),
      .term_o    (term_s[i]),
      .cout_o    (cout_s)
    );
  end

  assign wrap_s = g_dig[NDIG-1].cout_s;

  // Prescaler: preset clears it, otherwise it cycles 0..TICK_DIV-1 while enabled.
  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (tick_s) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Lap toggle and display source: the display register follows the
  // next-state values so it changes on the same edge as the count.
  always_comb begin
    lap_d = lap_q;
    lap_active_d = lap_active_q;
    disp_d = cnt_d_s;
    if (lap) begin
      lap_active_d = !lap_active_q;
      if (!lap_active_q) begin
        lap_d = cnt_q_s;
      end else begin
        lap_d = lap_q;
      end
    end else begin
      lap_active_d = lap_active_q;
    end
    if (lap_active_d) begin
      disp_d = lap_d;
    end else begin
      disp_d = cnt_d_s;
    end
  end

  // Top-level state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      disp_q       <= '0;
      cascade_q    <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      disp_q       <= disp_d;
      cascade_q    <= wrap_s;
    end
  end

  assign minute      = disp_q[CW-1 -: DIGIT_W*MIN_DIGITS];
  assign tenSecond   = disp_q[2*DIGIT_W +: DIGIT_W];
  assign oneSecond   = disp_q[DIGIT_W +: DIGIT_W];
  assign tenthSecond = disp_q[0 +: DIGIT_W];
  assign cascade     = cascade_q;
  assign atLimit     = at_limit_s;
  assign lapActive   = lap_active_q;

endmodule

// File: tb/tb_stopwatch_lap_counter.sv
// Directed bench: three instances (wrap, saturate, TICK_DIV=4) share stimulus;
// each phase checks the instance whose behaviour it targets.
module tb_stopwatch_lap_counter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        up;
  logic        load;
  logic [15:0] load_value;
  logic        lap;

  logic [3:0] d0_min, d0_ten, d0_one, d0_tth;
  logic       d0_casc, d0_lim, d0_lapa;
  logic [3:0] d1_min, d1_ten, d1_one, d1_tth;
  logic       d1_casc, d1_lim, d1_lapa;
  logic [3:0] d2_min, d2_ten, d2_one, d2_tth;
  logic       d2_casc, d2_lim, d2_lapa;

  int total;
  int passes;

  stopwatch_lap_counter #(.MIN_DIGITS(1), .TICK_DIV(1), .SATURATE(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .loadValue(load_value), .lap(lap),
    .minute(d0_min), .tenSecond(d0_ten), .oneSecond(d0_one), .tenthSecond(d0_tth),
    .cascade(d0_casc), .atLimit(d0_lim), .lapActive(d0_lapa)
  );

  stopwatch_lap_counter #(.MIN_DIGITS(1), .TICK_DIV(1), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .loadValue(load_value), .lap(lap),
    .minute(d1_min), .tenSecond(d1_ten), .oneSecond(d1_one), .tenthSecond(d1_tth),
    .cascade(d1_casc), .atLimit(d1_lim), .lapActive(d1_lapa)
  );

  stopwatch_lap_counter #(.MIN_DIGITS(1), .TICK_DIV(4), .SATURATE(0)) dut_div (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .loadValue(load_value), .lap(lap),
    .minute(d2_min), .tenSecond(d2_ten), .oneSecond(d2_one), .tenthSecond(d2_tth),
    .cascade(d2_casc), .atLimit(d2_lim), .lapActive(d2_lapa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] b1(input logic v);
    b1 = {15'd0, v};
  endfunction

  initial begin
    total = 0;
    passes = 0;
    reset = 1'b1;
    enable = 1'b1;
    up = 1'b1;
    load = 1'b0;
    load_value = 16'h0000;
    lap = 1'b0;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b0;
    #1;
    chk("rst_disp", {d0_min, d0_ten, d0_one, d0_tth}, 16'h0000);
    chk("rst_casc", b1(d0_casc), 16'd0);
    chk("rst_lapa", b1(d0_lapa), 16'd0);
    chk("rst_lim", b1(d0_lim), 16'd0);
    #1 reset = 1'b1;

    // Count up 12 ticks, never a cascade
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      chk("up_casc", b1(d0_casc), 16'd0);
    end
    chk("up12_disp", {d0_min, d0_ten, d0_one, d0_tth}, 16'h0012);

    // Count down 13 ticks through zero
    up = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      cyc(1);
      chk("dn_casc", b1(d0_casc), (k == 13) ? 16'd1 : 16'd0);
    end
    chk("dn13_disp", {d0_min, d0_ten, d0_one, d0_tth}, 16'h9599);
    chk("dn13_lim", b1(d0_lim), 16'd0);
    chk("sat_dn_disp", {d1_min, d1_ten, d1_one, d1_tth}, 16'h0000);
    chk("sat_dn_lim", b1(d1_lim), 16'd1);
    enable = 1'b0;
    cyc(1);
    chk("dn_casc_drop", b1(d0_casc), 16'd0);
    chk("hold_disp", {d0_min, d0_ten, d0_one, d0_tth}, 16'h9599);
    up = 1'b1;
    #1;
    chk("max_up_lim", b1(d0_lim), 16'd1);

    // Load 9.59.8 while at max with a pending up tick: load wins, no cascade
    enable = 1'b1;
    load_value = 16'h9598;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("load_disp", {d0_min, d0_ten, d0_one, d0_tth}, 16'h9598);
    chk("load_casc", b1(d0_casc), 16'd0);
    cyc(1);
    chk("ld1_disp", {d0_min, d0_ten, d0_one, d0_tth}, 16'h9599);
    chk("ld1_lim", b1(d0_lim), 16'd1);
    cyc(1);
    chk("wrap_disp", {d0_min, d0_ten, d0_one, d0_tth}, 16'h0000);
    chk("wrap_casc", b1(d0_casc), 16'd1);
    chk("sat_disp", {d1_min, d1_ten, d1_one, d1_tth}, 16'h9599);
    chk("sat_casc", b1(d1_casc), 16'd0);
    chk("sat_lim", b1(d1_lim), 16'd1);
    cyc(1);
    chk("wrap_casc_drop", b1(d0_casc), 16'd0);
    chk("wrap_next", {d0_min, d0_ten, d0_one, d0_tth}, 16'h0001);

    // Prescaler TICK_DIV=4
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    cyc(40);
    chk("div40_disp", {d2_min, d2_ten, d2_one, d2_tth}, 16'h0010);
    cyc(2);
    enable = 1'b0;
    cyc(20);
    chk("div_hold", {d2_min, d2_ten, d2_one, d2_tth}, 16'h0010);
    enable = 1'b1;
    cyc(1);
    chk("div_phase_a", {d2_min, d2_ten, d2_one, d2_tth}, 16'h0010);
    cyc(1);
    chk("div_phase_b", {d2_min, d2_ten, d2_one, d2_tth}, 16'h0011);

    // Lap freeze and release
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    cyc(5);
    chk("pre_lap", {d0_min, d0_ten, d0_one, d0_tth}, 16'h0005);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    chk("lap_disp", {d0_min, d0_ten, d0_one, d0_tth}, 16'h0005);
    chk("lap_act", b1(d0_lapa), 16'd1);
    for (int k = 1; k <= 9; k++) begin
      cyc(1);
      chk("lap_frozen", {d0_min, d0_ten, d0_one, d0_tth}, 16'h0005);
    end
    chk("lap_act_hold", b1(d0_lapa), 16'd1);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    chk("unlap_disp", {d0_min, d0_ten, d0_one, d0_tth}, 16'h0016);
    chk("unlap_act", b1(d0_lapa), 16'd0);

    // Clamped load, then async reset between edges
    enable = 1'b0;
    load_value = 16'hF7AC;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("clamp_disp", {d0_min, d0_ten, d0_one, d0_tth}, 16'h9599);
    load_value = 16'h0034;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("load_034", {d0_min, d0_ten, d0_one, d0_tth}, 16'h0034);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    chk("lap_before_rst", b1(d0_lapa), 16'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_disp", {d0_min, d0_ten, d0_one, d0_tth}, 16'h0000);
    chk("mid_rst_lapa", b1(d0_lapa), 16'd0);
    chk("mid_rst_casc", b1(d0_casc), 16'd0);
    reset = 1'b1;
    cyc(2);
    chk("post_rst_hold", {d0_min, d0_ten, d0_one, d0_tth}, 16'h0000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
